// File: rtl/ping_pong_ctrl_w.sv
// Two-bank WEST ping-pong buffer sequencer: fills one bank from the producer while the other drains.
// Optional sticky protocol-error checking is built when PPB_ERR_CHECK_EN is defined.
module ping_pong_ctrl_w #(
    parameter int unsigned TOTAL_MODULES = 4,
    parameter int unsigned COL_X         = 16,
    parameter int unsigned TOTAL_INPUT_W = 2,
    parameter int unsigned READ_PASSES   = 1,
    localparam int unsigned ADDR_WIDTH   = $clog2(COL_X * TOTAL_INPUT_W),
    localparam int unsigned SLICE_W      = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [SLICE_W-1:0]    i_cfg_slice,
    output logic [SLICE_W-1:0]    o_slicing_idx,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic                  i_rd_start,
    output logic                  o_rd_busy,
    output logic                  o_rd_valid,
    output logic                  o_rd_bank_sel,
    output logic                  o_rd_done,
    output logic [1:0]            o_full_cnt,
    output logic                  o_err,
    output logic                  o_bank0_ena,
    output logic                  o_bank0_enb,
    output logic                  o_bank0_wea,
    output logic                  o_bank0_web,
    output logic [ADDR_WIDTH-1:0] o_bank0_addra,
    output logic [ADDR_WIDTH-1:0] o_bank0_addrb,
    output logic                  o_bank1_ena,
    output logic                  o_bank1_enb,
    output logic                  o_bank1_wea,
    output logic                  o_bank1_web,
    output logic [ADDR_WIDTH-1:0] o_bank1_addra,
    output logic [ADDR_WIDTH-1:0] o_bank1_addrb
);

    localparam int unsigned CNT_W  = (COL_X > 1) ? $clog2(COL_X) : 1;
    localparam int unsigned PASS_W = (READ_PASSES > 1) ? $clog2(READ_PASSES) : 1;

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    if (TOTAL_INPUT_W != 2) begin : g_bad_input_w
        $error("ping_pong_ctrl_w: TOTAL_INPUT_W must be 2");
    end
    if (READ_PASSES < 1) begin : g_bad_read_passes
        $error("ping_pong_ctrl_w: READ_PASSES must be >= 1");
    end

    logic [1:0][1:0]     r_bank_st;
    logic [1:0][1:0]     w_bank_st_nxt;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [CNT_W-1:0]    r_wr_cnt;
    logic [CNT_W-1:0]    r_rd_cnt;
    logic [PASS_W-1:0]   r_rd_pass;
    logic                r_rd_busy;
    logic                r_rd_en;
    logic                r_rd_valid;
    logic                r_rd_done;
    logic                r_rd_bank_sel;
    logic [SLICE_W-1:0]  r_slice;

    logic                w_in_ready;
    logic                w_wr_acc;
    logic                w_wr_last;
    logic                w_rd_go;
    logic                w_rd_cnt_wrap;
    logic                w_rd_last_pass;
    logic                w_rd_last;
    logic                w_both_empty;
    logic [1:0]          w_full_cnt;
    logic [ADDR_WIDTH-1:0] w_wr_addra;
    logic [ADDR_WIDTH-1:0] w_wr_addrb;
    logic [ADDR_WIDTH-1:0] w_rd_addra;
    logic [ADDR_WIDTH-1:0] w_rd_addrb;
    logic [1:0]          w_wr_sel;
    logic [1:0]          w_rd_sel;
    logic [ADDR_WIDTH-1:0] w_addra [2];
    logic [ADDR_WIDTH-1:0] w_addrb [2];

    // in_ready is held low during reset so every output reads 0 while rst is asserted.
    assign w_in_ready = !i_rst && ((r_bank_st[r_wr_bank] == ST_EMPTY) ||
                                   (r_bank_st[r_wr_bank] == ST_FILLING));
    assign w_wr_acc   = i_in_valid && w_in_ready;
    assign w_wr_last  = (r_wr_cnt == CNT_W'(COL_X - 1));

    assign w_rd_go        = i_rd_start && !r_rd_busy && (r_bank_st[r_rd_bank] == ST_FULL);
    assign w_rd_cnt_wrap  = (r_rd_cnt == CNT_W'(COL_X - 1));
    assign w_rd_last_pass = (r_rd_pass == PASS_W'(READ_PASSES - 1));
    assign w_rd_last      = r_rd_en && w_rd_cnt_wrap && w_rd_last_pass;

    assign w_both_empty = (r_bank_st[0] == ST_EMPTY) && (r_bank_st[1] == ST_EMPTY);
    assign w_full_cnt   = {1'b0, (r_bank_st[0] == ST_FULL)} + {1'b0, (r_bank_st[1] == ST_FULL)};

    assign w_wr_addra = ADDR_WIDTH'(r_wr_cnt);
    assign w_wr_addrb = ADDR_WIDTH'(COL_X) + ADDR_WIDTH'(r_wr_cnt);
    assign w_rd_addra = ADDR_WIDTH'(r_rd_cnt);
    assign w_rd_addrb = ADDR_WIDTH'(COL_X) + ADDR_WIDTH'(r_rd_cnt);

    // Fill and drain touch different banks, so their state updates never collide.
    always_comb begin
        w_bank_st_nxt = r_bank_st;
        if (w_wr_acc) begin
            w_bank_st_nxt[r_wr_bank] = w_wr_last ? ST_FULL : ST_FILLING;
        end
        if (w_rd_go) begin
            w_bank_st_nxt[r_rd_bank] = ST_DRAINING;
        end
        if (r_rd_done) begin
            w_bank_st_nxt[r_rd_bank] = ST_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bank_st     <= '0;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
            r_rd_pass     <= '0;
            r_rd_busy     <= 1'b0;
            r_rd_en       <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_done     <= 1'b0;
            r_rd_bank_sel <= 1'b0;
            r_slice       <= '0;
        end else begin
            r_bank_st <= w_bank_st_nxt;

            if (w_wr_acc) begin
                if (w_wr_last) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end

            if (w_rd_go) begin
                r_rd_busy <= 1'b1;
                r_rd_en   <= 1'b1;
                r_rd_cnt  <= '0;
                r_rd_pass <= '0;
            end else if (r_rd_en) begin
                if (w_rd_cnt_wrap) begin
                    r_rd_cnt <= '0;
                    if (w_rd_last_pass) begin
                        r_rd_en <= 1'b0;
                    end else begin
                        r_rd_pass <= r_rd_pass + 1'b1;
                    end
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end

            // BRAM read latency is one cycle: valid/bank_sel/done trail the strobe stage.
            r_rd_valid    <= r_rd_en;
            r_rd_done     <= w_rd_last;
            r_rd_bank_sel <= r_rd_en ? r_rd_bank : 1'b0;

            if (r_rd_done) begin
                r_rd_busy <= 1'b0;
                r_rd_bank <= ~r_rd_bank;
            end

            if (w_both_empty && !r_rd_busy) begin
                r_slice <= i_cfg_slice;
            end
        end
    end

    always_comb begin
        w_wr_sel = '0;
        w_rd_sel = '0;
        for (int b = 0; b < 2; b++) begin
            w_wr_sel[b] = w_wr_acc && (r_wr_bank == 1'(b));
            w_rd_sel[b] = r_rd_en && (r_rd_bank == 1'(b));
            if (w_wr_sel[b]) begin
                w_addra[b] = w_wr_addra;
                w_addrb[b] = w_wr_addrb;
            end else if (w_rd_sel[b]) begin
                w_addra[b] = w_rd_addra;
                w_addrb[b] = w_rd_addrb;
            end else begin
                w_addra[b] = '0;
                w_addrb[b] = '0;
            end
        end
    end

    assign o_bank0_ena   = w_wr_sel[0] || w_rd_sel[0];
    assign o_bank0_enb   = w_wr_sel[0] || w_rd_sel[0];
    assign o_bank0_wea   = w_wr_sel[0];
    assign o_bank0_web   = w_wr_sel[0];
    assign o_bank0_addra = w_addra[0];
    assign o_bank0_addrb = w_addrb[0];
    assign o_bank1_ena   = w_wr_sel[1] || w_rd_sel[1];
    assign o_bank1_enb   = w_wr_sel[1] || w_rd_sel[1];
    assign o_bank1_wea   = w_wr_sel[1];
    assign o_bank1_web   = w_wr_sel[1];
    assign o_bank1_addra = w_addra[1];
    assign o_bank1_addrb = w_addrb[1];

    assign o_in_ready    = w_in_ready;
    assign o_rd_busy     = r_rd_busy;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_bank_sel = r_rd_bank_sel;
    assign o_rd_done     = r_rd_done;
    assign o_full_cnt    = w_full_cnt;
    assign o_slicing_idx = r_slice;

`ifdef PPB_ERR_CHECK_EN
    logic r_err;
    logic w_err_evt;

    assign w_err_evt = (i_in_valid && !w_in_ready) ||
                       (i_rd_start && (r_rd_busy || (w_full_cnt == 2'd0))) ||
                       (i_in_valid && (w_full_cnt == 2'd2));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule
